// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions.
//   ctr2_t    : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   IDX_*     : PHT indexing modes (global history only, or gshare)
//   ctr_next  : saturating counter step toward the resolved outcome
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_t;

  localparam int IDX_GLOBAL = 0;
  localparam int IDX_GSHARE = 1;

  function automatic ctr2_t ctr_next(input ctr2_t ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr2_t'(ctr + 2'd1);
    end
    return (ctr == SNT) ? SNT : ctr2_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of 2^HIST_LEN two-bit saturating counters.
//   clk, rst_n          : clock, synchronous active-low reset (counters -> WNT)
//   rd_idx / rd_ctr     : combinational read port (pre-update value on collision)
//   upd_en, upd_idx,
//   upd_taken           : synchronous update toward the resolved outcome
module bp_pht
  import bp_pkg::*;
#(
  parameter int HIST_LEN = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HIST_LEN-1:0] rd_idx,
  output ctr2_t               rd_ctr,
  input  logic                upd_en,
  input  logic [HIST_LEN-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int unsigned DEPTH = 1 << HIST_LEN;

  ctr2_t ctr [DEPTH];

  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[i] <= WNT;
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Branch predictor: direct-mapped BTB + 2-bit PHT indexed by global history
// (INDEX_MODE = IDX_GLOBAL) or by history XOR pc (INDEX_MODE = IDX_GSHARE).
// Predicts at stage 1, resolves at stage 3; the history snapshot used for each
// prediction travels with the branch so the update hits the exact counter and
// the speculative GHR can be repaired on mispredict.
//   clk, rst_n, stall                         : clock, sync active-low reset, freeze
//   pc_1 -> pred_taken_1/pred_target_1/pred_hist_1 : fetch-stage prediction
//   br_valid_3, pc_3, taken_3, target_3,
//   pred_taken_3, pred_target_3, hist_3       : stage-3 resolution inputs
//   flush, redirect_pc                        : mispredict squash and correct PC
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 8,
  parameter int HIST_LEN    = 5,
  parameter int INDEX_MODE  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [31:0]         pc_1,
  output logic                pred_taken_1,
  output logic [31:0]         pred_target_1,
  output logic [HIST_LEN-1:0] pred_hist_1,
  input  logic                br_valid_3,
  input  logic [31:0]         pc_3,
  input  logic                taken_3,
  input  logic [31:0]         target_3,
  input  logic                pred_taken_3,
  input  logic [31:0]         pred_target_3,
  input  logic [HIST_LEN-1:0] hist_3,
  output logic                flush,
  output logic [31:0]         redirect_pc
);

  localparam int unsigned IW = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
  localparam int unsigned TW = 30 - IW;
  localparam int unsigned NB = BTB_ENTRIES;

  logic          btb_valid  [NB];
  logic [TW-1:0] btb_tag    [NB];
  logic [31:0]   btb_target [NB];

  logic [HIST_LEN-1:0] ghr;

  function automatic logic [HIST_LEN-1:0] pht_index(input logic [HIST_LEN-1:0] hist,
                                                    input logic [31:0] pc);
    if (INDEX_MODE == IDX_GSHARE) begin
      return hist ^ pc[2 +: HIST_LEN];
    end
    return hist;
  endfunction

  // Stage-1 lookup
  logic [IW-1:0] bi_1;
  logic [TW-1:0] tag_1;
  logic          hit_1;
  ctr2_t         rd_ctr;

  assign bi_1  = pc_1[2 +: IW];
  assign tag_1 = pc_1[31:2+IW];
  assign hit_1 = btb_valid[bi_1] && (btb_tag[bi_1] == tag_1);

  assign pred_taken_1  = hit_1 & rd_ctr[1];
  assign pred_target_1 = pred_taken_1 ? btb_target[bi_1] : pc_1 + 32'd4;
  assign pred_hist_1   = ghr;

  // Stage-3 resolution
  logic [IW-1:0] bi_3;
  logic [TW-1:0] tag_3;
  logic          hit_3;
  logic          mis;
  logic          upd_pht;
  logic          upd_btb;

  assign bi_3  = pc_3[2 +: IW];
  assign tag_3 = pc_3[31:2+IW];
  assign hit_3 = btb_valid[bi_3] && (btb_tag[bi_3] == tag_3);

  assign mis = br_valid_3 &
               ((taken_3 != pred_taken_3) | (taken_3 & (target_3 != pred_target_3)));

  assign flush       = mis;
  assign redirect_pc = taken_3 ? target_3 : pc_3 + 32'd4;

  assign upd_pht = br_valid_3 & ~stall;
  assign upd_btb = upd_pht & taken_3;

  bp_pht #(
    .HIST_LEN(HIST_LEN)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pht_index(ghr, pc_1)),
    .rd_ctr   (rd_ctr),
    .upd_en   (upd_pht),
    .upd_idx  (pht_index(hist_3, pc_3)),
    .upd_taken(taken_3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (upd_btb) begin
      btb_valid[bi_3] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && upd_btb) begin
      if (!hit_3) begin
        btb_tag[bi_3] <= tag_3;
      end
      if (!hit_3 || (btb_target[bi_3] != target_3)) begin
        btb_target[bi_3] <= target_3;
      end
    end
  end

  // Repair takes priority over the speculative shift of a same-cycle hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (!stall) begin
      if (mis) begin
        ghr <= {hist_3[HIST_LEN-2:0], taken_3};
      end else if (hit_1) begin
        ghr <= {ghr[HIST_LEN-2:0], pred_taken_1};
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc_1[1:0], pc_3[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_valid_3, taken_3, pred_taken_3;
  logic [31:0] pc_1, pc_3, target_3, pred_target_3;
  logic [4:0]  hist_3;

  // index 0 = global-indexed instance, index 1 = gshare instance
  logic        ptk   [2];
  logic [31:0] ptgt  [2];
  logic [4:0]  phist [2];
  logic        fl    [2];
  logic [31:0] rdr   [2];

  always #5 clk = ~clk;

  gshare_btb_predictor #(.BTB_ENTRIES(8), .HIST_LEN(5), .INDEX_MODE(0)) dut_gl (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_1(pc_1),
    .pred_taken_1(ptk[0]), .pred_target_1(ptgt[0]), .pred_hist_1(phist[0]),
    .br_valid_3(br_valid_3), .pc_3(pc_3), .taken_3(taken_3), .target_3(target_3),
    .pred_taken_3(pred_taken_3), .pred_target_3(pred_target_3), .hist_3(hist_3),
    .flush(fl[0]), .redirect_pc(rdr[0]));

  gshare_btb_predictor #(.BTB_ENTRIES(8), .HIST_LEN(5), .INDEX_MODE(1)) dut_gs (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_1(pc_1),
    .pred_taken_1(ptk[1]), .pred_target_1(ptgt[1]), .pred_hist_1(phist[1]),
    .br_valid_3(br_valid_3), .pc_3(pc_3), .taken_3(taken_3), .target_3(target_3),
    .pred_taken_3(pred_taken_3), .pred_target_3(pred_target_3), .hist_3(hist_3),
    .flush(fl[1]), .redirect_pc(rdr[1]));

  typedef struct {
    bit          chk_pred;
    int          cyc;
    bit          e_ptk  [2];
    logic [31:0] e_ptgt [2];
    logic [4:0]  e_hist [2];
    bit          e_flush;
    logic [31:0] e_redir;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  bit          m_bv   [8];
  int unsigned m_tag  [8];
  logic [31:0] m_tgt  [8];
  int          m_pht  [2][32];
  int unsigned m_ghr  [2];

  function automatic int unsigned midx(int m, int unsigned h, logic [31:0] pc);
    return (m == 1) ? ((h ^ (pc >> 2)) % 32) : h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bv[i] = 0;
    for (int m = 0; m < 2; m++) begin
      m_ghr[m] = 0;
      for (int i = 0; i < 32; i++) m_pht[m][i] = 1;
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [31:0] p1,
                      input bit bv3, input logic [31:0] p3, input bit t3,
                      input logic [31:0] tg3, input bit pt3, input logic [31:0] ptg3,
                      input logic [4:0] h3);
    exp_t e;
    bit hit, mis;
    int unsigned bi, bi3;
    @(posedge clk);
    #1;
    rst_n = r; stall = s; pc_1 = p1; br_valid_3 = bv3; pc_3 = p3; taken_3 = t3;
    target_3 = tg3; pred_taken_3 = pt3; pred_target_3 = ptg3; hist_3 = h3;
    cyc++;
    e.cyc = cyc;
    e.chk_pred = r;  // state is only defined once a reset edge has passed
    bi  = (p1 >> 2) % 8;
    hit = m_bv[bi] && (m_tag[bi] == (p1 >> 5));
    for (int m = 0; m < 2; m++) begin
      e.e_ptk[m]  = hit && (m_pht[m][midx(m, m_ghr[m], p1)] >= 2);
      e.e_ptgt[m] = e.e_ptk[m] ? m_tgt[bi] : p1 + 32'd4;
      e.e_hist[m] = 5'(m_ghr[m]);
    end
    mis = bv3 && ((t3 != pt3) || (t3 && (tg3 != ptg3)));
    e.e_flush = mis;
    e.e_redir = t3 ? tg3 : p3 + 32'd4;
    sb.push_back(e);
    // state as seen after the coming edge
    if (!r) begin
      model_reset();
    end else if (!s) begin
      for (int m = 0; m < 2; m++) begin
        if (bv3) begin
          int unsigned i = midx(m, h3, p3);
          m_pht[m][i] = t3 ? ((m_pht[m][i] == 3) ? 3 : m_pht[m][i] + 1)
                           : ((m_pht[m][i] == 0) ? 0 : m_pht[m][i] - 1);
        end
        if (mis)      m_ghr[m] = ((int'(h3) << 1) | int'(t3)) % 32;
        else if (hit) m_ghr[m] = ((m_ghr[m] << 1) | int'(e.e_ptk[m])) % 32;
      end
      if (bv3 && t3) begin
        bi3 = (p3 >> 2) % 8;
        m_bv[bi3]  = 1;
        m_tag[bi3] = p3 >> 5;
        m_tgt[bi3] = tg3;
      end
    end
  endtask

  task automatic idle(input logic [31:0] p1);
    step(1, 0, p1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 5'd0);
  endtask

  task automatic resolve(input bit s, input logic [31:0] p1, input logic [31:0] p3,
                         input bit t3, input logic [31:0] tg3, input bit pt3,
                         input logic [31:0] ptg3, input logic [4:0] h3);
    step(1, s, p1, 1, p3, t3, tg3, pt3, ptg3, h3);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int m = 0; m < 2; m++) begin
          if (e.chk_pred) begin
            chk(m ? "gs_pred_taken" : "gl_pred_taken", e.cyc, 32'(ptk[m]), 32'(e.e_ptk[m]));
            chk(m ? "gs_pred_target" : "gl_pred_target", e.cyc, ptgt[m], e.e_ptgt[m]);
            chk(m ? "gs_pred_hist" : "gl_pred_hist", e.cyc, 32'(phist[m]), 32'(e.e_hist[m]));
          end
          chk(m ? "gs_flush" : "gl_flush", e.cyc, 32'(fl[m]), 32'(e.e_flush));
          chk(m ? "gs_redirect" : "gl_redirect", e.cyc, rdr[m], e.e_redir);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] IDLE_PC = 32'hFFF0_0000;
  logic [31:0] tpool [4] = '{32'h200, 32'h300, 32'h1000, 32'hFFFF_FFFC};

  initial begin
    int wait_cyc;
    rst_n = 0; stall = 0; pc_1 = 32'h100; br_valid_3 = 0; pc_3 = 0; taken_3 = 0;
    target_3 = 0; pred_taken_3 = 0; pred_target_3 = 0; hist_3 = 0;
    model_reset();

    step(0, 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 5'd0);
    step(0, 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 5'd0);
    idle(32'h100);                 // reset state: not taken, 0x104, hist 0
    idle(32'hFFFF_FFFC);           // fall-through wraps to 0

    // allocate 0x100 -> 0x200 with a mispredict, then saturate the counter
    resolve(0, IDLE_PC, 32'h100, 1, 32'h200, 0, 32'h104, 5'b11111);
    resolve(0, IDLE_PC, 32'h100, 1, 32'h200, 1, 32'h200, 5'b11111);
    resolve(0, IDLE_PC, 32'h100, 1, 32'h200, 1, 32'h200, 5'b11111);
    idle(32'h100);                 // predicts taken to 0x200
    // target change on a predicted-taken hit
    resolve(0, 32'h100, 32'h100, 1, 32'h300, 1, 32'h200, 5'b11111);
    idle(32'h100);                 // now predicts 0x300
    // repair wins over a same-cycle speculative shift
    resolve(0, 32'h100, 32'h40, 0, 32'h0, 1, 32'h300, 5'b00011);
    idle(IDLE_PC);                 // history 00110
    // mispredict held under stall, then applied once
    for (int i = 0; i < 3; i++)
      resolve(1, 32'h100, 32'h180, 1, 32'h1000, 0, 32'h184, 5'b01010);
    resolve(0, 32'h100, 32'h180, 1, 32'h1000, 0, 32'h184, 5'b01010);
    idle(32'h180);
    // aliasing: 0x04 trained taken, 0x08 trained not-taken, same history
    resolve(0, IDLE_PC, 32'h04, 1, 32'h200, 0, 32'h08, 5'b11111);
    resolve(0, IDLE_PC, 32'h04, 1, 32'h200, 1, 32'h200, 5'b11111);
    resolve(0, IDLE_PC, 32'h08, 1, 32'h300, 1, 32'h300, 5'b11111);
    for (int i = 0; i < 3; i++)
      resolve(0, IDLE_PC, 32'h08, 0, 32'h0, 0, 32'h0, 5'b11111);
    idle(32'h04);
    idle(IDLE_PC);
    idle(32'h08);

    // randomized traffic, with one mid-run reset
    for (int n = 0; n < 600; n++) begin
      logic [31:0] p1, p3, tg, ptg;
      bit bv, t, pt, s;
      p1 = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 7)) << 2);
      p3 = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 19) == 0) p1 = 32'hFFFF_FFFC;
      tg  = tpool[$urandom_range(0, 3)];
      ptg = ($urandom_range(0, 1) == 0) ? tg : tpool[$urandom_range(0, 3)];
      bv = ($urandom_range(0, 9) < 7);
      t  = $urandom_range(0, 1);
      pt = $urandom_range(0, 1);
      s  = ($urandom_range(0, 4) == 0);
      if (n == 300 || n == 301)
        step(0, 0, p1, 0, p3, t, tg, pt, ptg, 5'($urandom));
      else
        step(1, s, p1, bv, p3, t, tg, pt, ptg, 5'($urandom));
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d got=%0d expected=0", sb.size(), sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised branch predictor for the fetch/execute pipeline. It combines a direct-mapped BTB with a 2-bit-counter pattern history table (PHT), indexed by either the global history alone or gshare (PC XOR history). It predicts at stage 1 (fetch) and resolves at stage 3 (execute). Unlike the previous global-only predictor, it checkpoints history per prediction, repairs the speculative global history register (GHR) on mispredict, and updates each counter at the exact index that produced its prediction.

## Interface
- BTB_ENTRIES, 8: BTB depth; power of two, 2..256.
- HIST_LEN, 5: GHR width; PHT depth = 2^HIST_LEN; range 2..12.
- INDEX_MODE, 1: 0 = global (PHT index = GHR); 1 = gshare (GHR XOR pc[2 +: HIST_LEN]).
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- stall  in  1  pipeline stall; freezes all state.
- pc_1  in  32  fetch PC.
- pred_taken_1  out  1  predicted taken.
- pred_target_1  out  32  predicted next PC.
- pred_hist_1  out  HIST_LEN  GHR snapshot used for this prediction; the pipeline carries it to stage 3.
- br_valid_3  in  1  stage-3 instruction is a conditional branch.
- pc_3  in  32  stage-3 PC.
- taken_3  in  1  actual outcome.
- target_3  in  32  actual taken target.
- pred_taken_3, pred_target_3  in  1, 32  the prediction made for this branch, carried down the pipeline.
- hist_3  in  HIST_LEN  pred_hist_1 carried down the pipeline.
- flush  out  1  mispredict; squash stages 1-2.
- redirect_pc  out  32  correct next PC when flush = 1.

## Operation
- BTB entry: {valid, tag = pc[31:2+IW], target[31:0]}, with IW = log2(BTB_ENTRIES) and index = pc[2 +: IW].
- Prediction (combinational): hit_1 = valid & tag match; PHT index from GHR and pc_1 per INDEX_MODE; pred_taken_1 = hit_1 & counter[1]; pred_target_1 = pred_taken_1 ? BTB target : pc_1 + 4 (32-bit wrap); pred_hist_1 = GHR.
- Mispredict: mis = br_valid_3 & (taken_3 != pred_taken_3 | (taken_3 & target_3 != pred_target_3)).
- flush = mis; redirect_pc = taken_3 ? target_3 : pc_3 + 4. Both are driven combinationally, independent of stall.
- PHT update when br_valid_3 & !stall:
  - Index is recomputed from hist_3 and pc_3.
  - Counter is saturating 00↔01↔10↔11: increment on taken, decrement on not-taken; saturates at 00 and 11.
- BTB update when br_valid_3 & !stall & taken_3:
  - miss: allocate/overwrite the entry (valid = 1, tag, target).
  - hit with target mismatch: rewrite target only.
  - Not-taken branches never allocate and never invalidate.
- GHR update when !stall, in priority order:
  1. mis: GHR ← {hist_3[HIST_LEN-2:0], taken_3} (repair).
  2. else if hit_1: GHR ← {GHR[HIST_LEN-2:0], pred_taken_1} (speculative shift).
  3. else hold.
- Reset: BTB valid bits cleared, PHT counters = 01 (weakly not-taken), GHR = 0.

## Timing
- Prediction: zero latency (same cycle as pc_1). Updates are visible to predictions on the next cycle.
- Same-cycle read and update of the same BTB/PHT entry: the prediction sees the pre-update value.
- Repair plus a stage-1 hit in the same cycle: repair wins; the stage-1 instruction is squashed by flush anyway.
- During stall:
  - flush and redirect_pc still reflect the stage-3 inputs.
  - No state changes.
  - The pipeline holds the stage-3 inputs stable, so the update happens once, on the first unstalled cycle.
- Outputs during and just after reset:
  - pred_taken_1 = 0, pred_target_1 = pc_1 + 4, pred_hist_1 = 0.
  - flush / redirect_pc follow the stage-3 inputs; the pipeline holds br_valid_3 = 0 during reset.
- Reset asserted mid-operation discards all state and all pending updates in that cycle.
- GHR wrap: the shift drops the MSB; no overflow handling is needed.

## Structure
- Shared package bp_pkg:
  - typedef ctr2_t (2 bits) and constants SNT = 00, WNT = 01, WT = 10, ST = 11.
  - localparam IDX_GLOBAL = 0, IDX_GSHARE = 1.
  - Function ctr_next(ctr2_t, taken).
- Sub-module bp_pht:
  - Parametrised by HIST_LEN.
  - One combinational read port, one synchronous update port, reset to WNT.
- BTB and GHR stay in the top level.

## Test plan
- Reset, then pc_1 = 0x100 → pred_taken_1 = 0, pred_target_1 = 0x104, pred_hist_1 = 0, flush = 0.
- Resolve pc_3 = 0x100, taken to 0x200, pred_taken_3 = 0 → flush = 1, redirect_pc = 0x200, BTB allocated. Two more taken resolves at the same history index → counter 11. Then pc_1 = 0x100 → pred_taken_1 = 1, pred_target_1 = 0x200.
- BTB hit, predicted taken, resolve with target_3 = 0x300 ≠ pred_target_3 = 0x200 → flush = 1, redirect_pc = 0x300. Next prediction gives 0x300.
- HIST_LEN = 5, GHR = 10110, hit_1 with pred_taken_1 = 1, same-cycle mispredict with hist_3 = 00011, taken_3 = 0 → GHR = 00110 (repair, not 01101).
- Mispredict presented with stall = 1 for 3 cycles → flush = 1 throughout, GHR/PHT/BTB unchanged. Update applied exactly once on the first unstalled cycle.
- INDEX_MODE = 1: two branches at pc 0x04 and 0x08 with the same GHR train to opposite directions and predict independently. INDEX_MODE = 0: the same sequence aliases onto one counter.
